bw_write_arbiter: RTL and testbench

Two-requester arbiter for the board-write bus (`bw_*`) that drives the DAC block and power-control register. It sits between the Firewire and Ethernet write paths, each of which may contain a real-time block writer, and the shared board-register write port. It grants the bus per transaction, forwards the winner's strobes with one register stage, and rejects and counts transactions that start while the bus is owned. It also cuts off a requester that holds the bus too long.

---
 rtl/bw_write_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_bw_write_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bw_write_arbiter.sv
// bw_write_arbiter
//   Two-requester arbiter for the board-write bus feeding the DAC block and
//   the power-control register. A requester wins the bus only on a rising
//   edge of its write_en envelope; the winner's strobes, address and data
//   are forwarded through one register stage until its envelope drops or it
//   overstays the timeout. Rises that cannot be granted are counted as drops.
//
// Ports
//   clk, reset            : clock, synchronous active-low reset
//   reqN_write_en         : requester N transaction envelope (N = 0, 1)
//   reqN_reg_wen          : requester N register write strobe
//   reqN_block_wen        : requester N block write strobe
//   reqN_block_wstart     : requester N block start strobe
//   reqN_reg_waddr[7:0]   : requester N address
//   reqN_reg_wdata[31:0]  : requester N data
//   bw_*                  : arbitrated, registered copy of the owner's inputs
//   gnt0, gnt1            : bw_* currently carries requester 0 / 1
//   busy                  : arbiter is not idle
//   timeout_flag          : sticky, set when an owner is forcibly released
//   timeout_clr           : clears timeout_flag (a coincident set wins)
//   drop_cnt[7:0]         : saturating count of rejected transactions
//   drop_clr              : clears drop_cnt (coincident drops are kept)
module bw_write_arbiter #(
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_write_en,
  input  logic        req0_reg_wen,
  input  logic        req0_block_wen,
  input  logic        req0_block_wstart,
  input  logic [7:0]  req0_reg_waddr,
  input  logic [31:0] req0_reg_wdata,
  input  logic        req1_write_en,
  input  logic        req1_reg_wen,
  input  logic        req1_block_wen,
  input  logic        req1_block_wstart,
  input  logic [7:0]  req1_reg_waddr,
  input  logic [31:0] req1_reg_wdata,
  output logic        bw_write_en,
  output logic        bw_reg_wen,
  output logic        bw_block_wen,
  output logic        bw_block_wstart,
  output logic [7:0]  bw_reg_waddr,
  output logic [31:0] bw_reg_wdata,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        timeout_flag,
  input  logic        timeout_clr,
  output logic [7:0]  drop_cnt,
  input  logic        drop_clr
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  // With no holdoff configured a finished grant returns straight to IDLE.
  localparam logic [1:0]  POST     = (GAP_CYCLES == 0) ? IDLE : GAP;
  localparam logic [3:0]  GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  function automatic logic [7:0] sat_add(input logic [7:0] acc, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, acc} + {7'd0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  logic [1:0]  state, state_nxt;
  logic        prev0, prev1;
  logic        blk0, blk1;
  logic        blk0_set, blk1_set;
  logic        last_gnt, last_nxt;
  logic [3:0]  gap_cnt, gap_nxt;
  logic [15:0] to_cnt, to_nxt;
  logic        to_hit;
  logic [1:0]  drop_inc;
  logic        fwd0, fwd1;
  logic        rise0, rise1;
  logic        timeout_flag_r;
  logic [7:0]  drop_cnt_r;

  logic              sel_write_en, sel_reg_wen, sel_block_wen, sel_block_wstart;
  logic [ADDR_W-1:0] sel_reg_waddr;
  logic [DATA_W-1:0] sel_reg_wdata;

  logic              bw_write_en_p1, bw_reg_wen_p1, bw_block_wen_p1, bw_block_wstart_p1;
  logic [ADDR_W-1:0] bw_reg_waddr_p1;
  logic [DATA_W-1:0] bw_reg_wdata_p1;
  logic              gnt0_p1, gnt1_p1;

  // A block left over from a timeout only matters until the envelope drops;
  // the rise detector already hides a still-high envelope, the block makes
  // the intent explicit.
  assign rise0 = req0_write_en & ~prev0 & ~blk0;
  assign rise1 = req1_write_en & ~prev1 & ~blk1;

  // Stage p0: arbitration, ownership tracking and source select
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    to_nxt    = to_cnt;
    last_nxt  = last_gnt;
    fwd0      = 1'b0;
    fwd1      = 1'b0;
    drop_inc  = 2'd0;
    to_hit    = 1'b0;
    blk0_set  = 1'b0;
    blk1_set  = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester that was not granted last time wins.
        if (rise0 && (!rise1 || last_gnt)) begin
          state_nxt = OWN0;
          fwd0      = 1'b1;
          to_nxt    = 16'd1;
          last_nxt  = 1'b0;
          drop_inc  = {1'b0, rise1};
        end else if (rise1) begin
          state_nxt = OWN1;
          fwd1      = 1'b1;
          to_nxt    = 16'd1;
          last_nxt  = 1'b1;
          drop_inc  = {1'b0, rise0};
        end
      end
      OWN0: begin
        drop_inc = {1'b0, rise0} + {1'b0, rise1};
        if (!req0_write_en) begin
          state_nxt = POST;
          gap_nxt   = GAP_LOAD;
        end else if (to_cnt >= TO_LIMIT) begin
          state_nxt = POST;
          gap_nxt   = GAP_LOAD;
          to_hit    = 1'b1;
          blk0_set  = 1'b1;
        end else begin
          fwd0   = 1'b1;
          to_nxt = to_cnt + 16'd1;
        end
      end
      OWN1: begin
        drop_inc = {1'b0, rise0} + {1'b0, rise1};
        if (!req1_write_en) begin
          state_nxt = POST;
          gap_nxt   = GAP_LOAD;
        end else if (to_cnt >= TO_LIMIT) begin
          state_nxt = POST;
          gap_nxt   = GAP_LOAD;
          to_hit    = 1'b1;
          blk1_set  = 1'b1;
        end else begin
          fwd1   = 1'b1;
          to_nxt = to_cnt + 16'd1;
        end
      end
      GAP: begin
        drop_inc = {1'b0, rise0} + {1'b0, rise1};
        if (gap_cnt == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    sel_write_en     = 1'b0;
    sel_reg_wen      = 1'b0;
    sel_block_wen    = 1'b0;
    sel_block_wstart = 1'b0;
    sel_reg_waddr    = '0;
    sel_reg_wdata    = '0;
    if (fwd0) begin
      sel_write_en     = req0_write_en;
      sel_reg_wen      = req0_reg_wen;
      sel_block_wen    = req0_block_wen;
      sel_block_wstart = req0_block_wstart;
      sel_reg_waddr    = req0_reg_waddr;
      sel_reg_wdata    = req0_reg_wdata;
    end else if (fwd1) begin
      sel_write_en     = req1_write_en;
      sel_reg_wen      = req1_reg_wen;
      sel_block_wen    = req1_block_wen;
      sel_block_wstart = req1_block_wstart;
      sel_reg_waddr    = req1_reg_waddr;
      sel_reg_wdata    = req1_reg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      prev0          <= 1'b1;
      prev1          <= 1'b1;
      blk0           <= 1'b0;
      blk1           <= 1'b0;
      last_gnt       <= 1'b1;
      gap_cnt        <= 4'd0;
      to_cnt         <= 16'd0;
      timeout_flag_r <= 1'b0;
      drop_cnt_r     <= 8'd0;
    end else begin
      state    <= state_nxt;
      prev0    <= req0_write_en;
      prev1    <= req1_write_en;
      blk0     <= blk0_set | (blk0 & req0_write_en);
      blk1     <= blk1_set | (blk1 & req1_write_en);
      last_gnt <= last_nxt;
      gap_cnt  <= gap_nxt;
      to_cnt   <= to_nxt;
      if (to_hit) begin
        timeout_flag_r <= 1'b1;
      end else if (timeout_clr) begin
        timeout_flag_r <= 1'b0;
      end
      if (drop_clr) begin
        drop_cnt_r <= {6'd0, drop_inc};
      end else begin
        drop_cnt_r <= sat_add(drop_cnt_r, drop_inc);
      end
    end
  end

  // Stage p1: registered bus outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      bw_write_en_p1     <= 1'b0;
      bw_reg_wen_p1      <= 1'b0;
      bw_block_wen_p1    <= 1'b0;
      bw_block_wstart_p1 <= 1'b0;
      bw_reg_waddr_p1    <= '0;
      bw_reg_wdata_p1    <= '0;
      gnt0_p1            <= 1'b0;
      gnt1_p1            <= 1'b0;
    end else begin
      bw_write_en_p1     <= sel_write_en;
      bw_reg_wen_p1      <= sel_reg_wen;
      bw_block_wen_p1    <= sel_block_wen;
      bw_block_wstart_p1 <= sel_block_wstart;
      bw_reg_waddr_p1    <= sel_reg_waddr;
      bw_reg_wdata_p1    <= sel_reg_wdata;
      gnt0_p1            <= fwd0;
      gnt1_p1            <= fwd1;
    end
  end

  assign bw_write_en     = bw_write_en_p1;
  assign bw_reg_wen      = bw_reg_wen_p1;
  assign bw_block_wen    = bw_block_wen_p1;
  assign bw_block_wstart = bw_block_wstart_p1;
  assign bw_reg_waddr    = bw_reg_waddr_p1;
  assign bw_reg_wdata    = bw_reg_wdata_p1;
  assign gnt0            = gnt0_p1;
  assign gnt1            = gnt1_p1;
  assign busy            = (state != IDLE);
  assign timeout_flag    = timeout_flag_r;
  assign drop_cnt        = drop_cnt_r;

endmodule

// File: tb/tb_bw_write_arbiter.sv
// Directed bench for bw_write_arbiter (GAP_CYCLES=1, TIMEOUT_CYCLES=16).
// Inputs change 1 time unit after a rising edge; outputs are read at the
// same point, so after step() they show the inputs presented that cycle.
module tb_bw_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_write_en, req0_reg_wen, req0_block_wen, req0_block_wstart;
  logic [7:0]  req0_reg_waddr;
  logic [31:0] req0_reg_wdata;
  logic        req1_write_en, req1_reg_wen, req1_block_wen, req1_block_wstart;
  logic [7:0]  req1_reg_waddr;
  logic [31:0] req1_reg_wdata;
  logic        bw_write_en, bw_reg_wen, bw_block_wen, bw_block_wstart;
  logic [7:0]  bw_reg_waddr;
  logic [31:0] bw_reg_wdata;
  logic        gnt0, gnt1, busy, timeout_flag, timeout_clr;
  logic [7:0]  drop_cnt;
  logic        drop_clr;

  int checks = 0;
  int errors = 0;

  // {write_en, reg_wen, block_wen, block_wstart, gnt0, gnt1}
  logic [5:0] obs_s;
  assign obs_s = {bw_write_en, bw_reg_wen, bw_block_wen, bw_block_wstart, gnt0, gnt1};

  always #5 clk = ~clk;

  bw_write_arbiter #(.GAP_CYCLES(1), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req0_write_en(req0_write_en), .req0_reg_wen(req0_reg_wen),
    .req0_block_wen(req0_block_wen), .req0_block_wstart(req0_block_wstart),
    .req0_reg_waddr(req0_reg_waddr), .req0_reg_wdata(req0_reg_wdata),
    .req1_write_en(req1_write_en), .req1_reg_wen(req1_reg_wen),
    .req1_block_wen(req1_block_wen), .req1_block_wstart(req1_block_wstart),
    .req1_reg_waddr(req1_reg_waddr), .req1_reg_wdata(req1_reg_wdata),
    .bw_write_en(bw_write_en), .bw_reg_wen(bw_reg_wen),
    .bw_block_wen(bw_block_wen), .bw_block_wstart(bw_block_wstart),
    .bw_reg_waddr(bw_reg_waddr), .bw_reg_wdata(bw_reg_wdata),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .timeout_flag(timeout_flag), .timeout_clr(timeout_clr),
    .drop_cnt(drop_cnt), .drop_clr(drop_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic we, input logic rw, input logic bk, input logic ws,
                        input logic [7:0] a, input logic [31:0] d);
    req0_write_en = we; req0_reg_wen = rw; req0_block_wen = bk; req0_block_wstart = ws;
    req0_reg_waddr = a; req0_reg_wdata = d;
  endtask

  task automatic drive1(input logic we, input logic rw, input logic bk, input logic ws,
                        input logic [7:0] a, input logic [31:0] d);
    req1_write_en = we; req1_reg_wen = rw; req1_block_wen = bk; req1_block_wstart = ws;
    req1_reg_waddr = a; req1_reg_wdata = d;
  endtask

  initial begin
    logic [5:0] exp_s;
    int exp_drop;

    reset = 1'b0; timeout_clr = 1'b0; drop_clr = 1'b0;
    // req0 envelope already high while reset is held and released
    drive0(1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 32'h0000_7777);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step(); step();
    chk("rst_strobes", 32'(obs_s), 32'h0);
    chk("rst_addr", 32'(bw_reg_waddr), 32'h0);
    chk("rst_data", bw_reg_wdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tflag", 32'(timeout_flag), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_no_grant", 32'(obs_s), 32'h0);
      chk("held_no_drop", 32'(drop_cnt), 32'h0);
    end
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step();

    // Tie after reset: requester 0 wins, requester 1 dropped
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 32'hA0A0_A0A0);
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 8'h20, 32'hB0B0_B0B0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tie0_strobes", 32'(obs_s), 32'b110010);
      chk("tie0_addr", 32'(bw_reg_waddr), 32'h10);
      chk("tie0_data", bw_reg_wdata, 32'hA0A0_A0A0);
    end
    chk("tie0_drop", 32'(drop_cnt), 32'd1);
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
    chk("tie0_end", 32'(obs_s), 32'h0);
    chk("tie0_gap_busy", 32'(busy), 32'd1);
    step();
    chk("tie0_idle_busy", 32'(busy), 32'd0);

    // Second tie: requester 1 wins this time
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 32'hA0A0_A0A0);
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 8'h20, 32'hB0B0_B0B0);
    step();
    chk("tie1_strobes", 32'(obs_s), 32'b110001);
    chk("tie1_addr", 32'(bw_reg_waddr), 32'h20);
    chk("tie1_data", bw_reg_wdata, 32'hB0B0_B0B0);
    chk("tie1_drop", 32'(drop_cnt), 32'd2);
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step(); step();

    drop_clr = 1'b1;
    step();
    drop_clr = 1'b0;
    chk("drop_clr", 32'(drop_cnt), 32'd0);

    // Req0 12-cycle transaction, req1 rises 3 cycles in and is rejected
    for (int i = 0; i < 12; i++) begin
      drive0(1'b1, (i == 4), 1'b0, (i < 4), 8'h01, 32'h8000_1234);
      if (i >= 3 && i <= 6) drive1(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 32'hDEAD_BEEF);
      else drive1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      step();
      exp_s = {1'b1, (i == 4), 1'b0, (i < 4), 1'b1, 1'b0};
      chk("txn_strobes", 32'(obs_s), 32'(exp_s));
      chk("txn_addr", 32'(bw_reg_waddr), 32'h01);
      chk("txn_data", bw_reg_wdata, 32'h8000_1234);
    end
    chk("txn_drop_own", 32'(drop_cnt), 32'd1);
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
    chk("txn_end_strobes", 32'(obs_s), 32'h0);
    chk("txn_end_addr", 32'(bw_reg_waddr), 32'h0);
    chk("txn_end_data", bw_reg_wdata, 32'h0);
    chk("txn_end_busy", 32'(busy), 32'd1);
    // Rise 1 cycle after the end lands in GAP: rejected
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 32'hDEAD_BEEF);
    step();
    chk("gap_rise_strobes", 32'(obs_s), 32'h0);
    chk("gap_rise_drop", 32'(drop_cnt), 32'd2);
    // Rise 2 cycles after the end is granted
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive0(1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 32'h1234_5678);
    step();
    chk("post_gap_strobes", 32'(obs_s), 32'b101010);
    chk("post_gap_addr", 32'(bw_reg_waddr), 32'h02);
    chk("post_gap_drop", 32'(drop_cnt), 32'd2);
    step();
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step(); step();

    // Timeout: req0 holds write_en for 40 cycles, cut off after 16
    for (int i = 0; i < 40; i++) begin
      drive0(1'b1, i[0], 1'b0, 1'b0, 8'h33, 32'(i));
      step();
      exp_s = (i < 16) ? {1'b1, i[0], 1'b0, 1'b0, 1'b1, 1'b0} : 6'b0;
      chk("to_strobes", 32'(obs_s), 32'(exp_s));
      chk("to_data", bw_reg_wdata, (i < 16) ? 32'(i) : 32'h0);
    end
    chk("to_flag", 32'(timeout_flag), 32'd1);
    chk("to_no_drop", 32'(drop_cnt), 32'd2);
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
    drive0(1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 32'h0000_0044);
    step();
    chk("to_regrant_strobes", 32'(obs_s), 32'b100010);
    chk("to_regrant_addr", 32'(bw_reg_waddr), 32'h44);
    chk("to_flag_sticky", 32'(timeout_flag), 32'd1);

    // Reset in the middle of that grant
    reset = 1'b0;
    step();
    chk("midrst_strobes", 32'(obs_s), 32'h0);
    chk("midrst_addr", 32'(bw_reg_waddr), 32'h0);
    chk("midrst_data", bw_reg_wdata, 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tflag", 32'(timeout_flag), 32'd0);
    chk("midrst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b1;
    step();
    chk("midrst_no_resume", 32'(obs_s), 32'h0);
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step();
    chk("midrst_no_drop", 32'(drop_cnt), 32'd0);

    // Drop saturation: 7 rejected req1 rises per req0 grant
    exp_drop = 0;
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 14; k++) begin
        drive0(1'b1, 1'b0, 1'b1, 1'b0, 8'(r), 32'(r));
        drive1(k[0], 1'b1, 1'b0, 1'b0, 8'hEE, 32'hEEEE_EEEE);
        step();
      end
      drive0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      drive1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      step(); step();
      exp_drop += 7;
      chk("sat_drop", 32'(drop_cnt), (exp_drop > 255) ? 32'd255 : 32'(exp_drop));
    end

    // drop_clr coincident with a rejection keeps that rejection
    for (int k = 0; k < 14; k++) begin
      drive0(1'b1, 1'b0, 1'b1, 1'b0, 8'h66, 32'h66);
      drive1(k[0], 1'b1, 1'b0, 1'b0, 8'hEE, 32'hEEEE_EEEE);
      drop_clr = (k == 3);
      step();
      if (k == 3) chk("clr_with_drop", 32'(drop_cnt), 32'd1);
    end
    drop_clr = 1'b0;
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    step(); step();
    chk("clr_then_count", 32'(drop_cnt), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
